sort5_bus_master: RTL
=====================

// Module: sort5_bus_master
// PURPOSE
//  Bus-master counterpart of the 5-entry sort peripheral. On iStart it writes five
//  operands to the peripheral (addr 0-4), writes the start register (addr 5), waits
//  for the sort, then reads the sorted words back (addr 6-10). Sits between local
//  control logic and the peripheral's chip-select/read/write/address slave port.
// PARAMETERS
//  DATA_WIDTH   32  width of each operand and of the bus data paths
//  WAIT_CYCLES  2   idle cycles between the start write and the first read; legal range >= 2
// PORTS
//  iClk           in   1              system clock; all logic on rising edge
//  iReset         in   1              synchronous, active-high reset
//  iStart         in   1              run request; sampled only in IDLE
//  iOperands      in   5*DATA_WIDTH   operand k at [k*DATA_WIDTH +: DATA_WIDTH]
//  oBusy          out  1              high in every state except IDLE
//  oDone          out  1              one-cycle pulse; oResult valid from this cycle on
//  oResult        out  5*DATA_WIDTH   sorted word k (ascending, unsigned) at [k*DATA_WIDTH +: DATA_WIDTH]
//  oChipSelect_n  out  1              peripheral chip select, active-low
//  oWrite_n       out  1              peripheral write strobe, active-low
//  oRead_n        out  1              peripheral read strobe, active-low
//  oAddress       out  4              peripheral register address
//  oWriteData     out  DATA_WIDTH     peripheral write data
//  iReadData      in   DATA_WIDTH     peripheral read data; valid one cycle after the read strobe
// BEHAVIOUR
//  Reset (iReset=1 at an edge): state=IDLE; oBusy=0, oDone=0, oResult=0;
//   oChipSelect_n=1, oWrite_n=1, oRead_n=1, oAddress=0, oWriteData=0. Reset wins over all.
//   Reset mid-run aborts immediately; bus strobes deassert the following cycle; no oDone.
//  All bus outputs are registered. Idle bus: CS_n=WR_n=RD_n=1, address/data = 0.
//  FSM (one state per cycle unless stated); cycle 0 = edge at which iStart=1 is seen in IDLE:
//   IDLE  : on iStart, latch iOperands into internal copy -> WRITE(idx=0).
//   WRITE : cycles 1-5; CS_n=0, WR_n=0, addr=idx, data=operand[idx]; idx 4 -> KICK.
//   KICK  : cycle 6; CS_n=0, WR_n=0, addr=5, data=0 -> WAIT.
//   WAIT  : WAIT_CYCLES cycles, bus idle; counter reloads on entry -> RREQ(k=0).
//   RREQ  : CS_n=0, RD_n=0, addr=6+k -> RCAP.
//   RCAP  : bus idle; capture iReadData into result word k; k=4 -> DONE, else k+1 -> RREQ.
//   DONE  : oDone=1 for this cycle only -> IDLE.
//  Default timing (WAIT_CYCLES=2): WAIT cycles 7-8, reads cycles 9-18, oDone in cycle 19,
//   IDLE in cycle 20. General: oDone in cycle 17+WAIT_CYCLES.
//  WR_n and RD_n never low in the same cycle; CS_n low iff one strobe is low.
//  iStart while oBusy=1 (including the DONE cycle) is ignored, not queued; a new run
//   may start no earlier than the first IDLE cycle.
//  iOperands changes after cycle 0 do not affect the current run.
//  oResult holds its last value until the next run's captures overwrite it word by word
//   or until reset; consumers use it only after oDone.
//  oBusy=1 from cycle 1 through the DONE cycle inclusive.
//  The block does no comparison itself; ordering is the peripheral's (unsigned) result.
// TESTING (bench pairs the block with a model of the sort peripheral)
//  Operands {7,1,9,3,5} (k=0..4), iStart pulse -> writes addr 0..5, reads addr 6..10,
//   oDone in cycle 19, oResult words = {1,3,5,7,9}.
//  Operands {FFFFFFFF,0,80000000,0,1} -> oResult {0,0,1,80000000,FFFFFFFF} (unsigned, duplicates).
//  iStart held high for 30 cycles -> two runs; second run's cycle 0 = first IDLE cycle (20),
//   no bus activity from cycles 1-19 of the first run is repeated.
//  iReset=1 in cycle 8 (WAIT) -> next cycle all strobes high, oBusy=0, oResult=0, no oDone.
//  WAIT_CYCLES=5 -> first read in cycle 12, oDone in cycle 22, same sorted result.
//  Bus protocol check each cycle: never WR_n=RD_n=0; CS_n=0 iff a strobe is low.

Source files
------------

// File: rtl/sort5_bus_master.sv
// Bus master that loads five operands into the sort peripheral, starts it,
// waits, and reads the five sorted words back into oResult.
module sort5_bus_master #(
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    iClk,
    input  logic                    iReset,
    input  logic                    iStart,
    input  logic [5*DATA_WIDTH-1:0] iOperands,
    output logic                    oBusy,
    output logic                    oDone,
    output logic [5*DATA_WIDTH-1:0] oResult,
    output logic                    oChipSelect_n,
    output logic                    oWrite_n,
    output logic                    oRead_n,
    output logic [3:0]              oAddress,
    output logic [DATA_WIDTH-1:0]   oWriteData,
    input  logic [DATA_WIDTH-1:0]   iReadData
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_KICK  = 3'd2,
        S_WAIT  = 3'd3,
        S_RREQ  = 3'd4,
        S_RCAP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                  r_state;
    logic [2:0]              r_idx;
    logic [WCW-1:0]          r_wait;
    logic [5*DATA_WIDTH-1:0] r_ops;

    state_t                  w_next_state;
    logic [2:0]              w_next_idx;
    logic [WCW-1:0]          w_next_wait;
    logic [5*DATA_WIDTH-1:0] w_op_src;
    logic                    w_cs_n;
    logic                    w_wr_n;
    logic                    w_rd_n;
    logic [3:0]              w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;

    // Next-state logic; r_idx is the write index in WRITE and the read word in RREQ/RCAP.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_wait  = r_wait;
        case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_next_state = S_WRITE;
                    w_next_idx   = 3'd0;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WRITE: begin
                if (r_idx == 3'd4) begin
                    w_next_state = S_KICK;
                    w_next_idx   = 3'd0;
                end else begin
                    w_next_idx   = r_idx + 3'd1;
                end
            end
            S_KICK: begin
                w_next_state = S_WAIT;
                w_next_wait  = WCW'(WAIT_CYCLES - 1);
            end
            S_WAIT: begin
                if (r_wait == {WCW{1'b0}}) begin
                    w_next_state = S_RREQ;
                    w_next_idx   = 3'd0;
                end else begin
                    w_next_wait  = r_wait - WCW'(1);
                end
            end
            S_RREQ: begin
                w_next_state = S_RCAP;
            end
            S_RCAP: begin
                if (r_idx == 3'd4) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RREQ;
                    w_next_idx   = r_idx + 3'd1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_idx   = 3'd0;
            end
        endcase
    end

    // Operands come straight from the input on the accepting edge, before the copy exists.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_op_src = iOperands;
        end else begin
            w_op_src = r_ops;
        end
    end

    // Bus values for the coming cycle, decoded from the next state so they can be registered.
    always_comb begin
        w_cs_n  = 1'b1;
        w_wr_n  = 1'b1;
        w_rd_n  = 1'b1;
        w_addr  = 4'd0;
        w_wdata = {DATA_WIDTH{1'b0}};
        case (w_next_state)
            S_WRITE: begin
                w_cs_n  = 1'b0;
                w_wr_n  = 1'b0;
                w_addr  = {1'b0, w_next_idx};
                w_wdata = w_op_src[w_next_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            S_KICK: begin
                w_cs_n  = 1'b0;
                w_wr_n  = 1'b0;
                w_addr  = 4'd5;
            end
            S_RREQ: begin
                w_cs_n  = 1'b0;
                w_rd_n  = 1'b0;
                w_addr  = 4'd6 + {1'b0, w_next_idx};
            end
            default: begin
                w_cs_n  = 1'b1;
            end
        endcase
    end

    // State, counters, operand copy, result capture and registered outputs.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state       <= S_IDLE;
            r_idx         <= 3'd0;
            r_wait        <= {WCW{1'b0}};
            r_ops         <= {(5*DATA_WIDTH){1'b0}};
            oResult       <= {(5*DATA_WIDTH){1'b0}};
            oBusy         <= 1'b0;
            oDone         <= 1'b0;
            oChipSelect_n <= 1'b1;
            oWrite_n      <= 1'b1;
            oRead_n       <= 1'b1;
            oAddress      <= 4'd0;
            oWriteData    <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state       <= w_next_state;
            r_idx         <= w_next_idx;
            r_wait        <= w_next_wait;
            if (r_state == S_IDLE && iStart) begin
                r_ops <= iOperands;
            end
            // Read data arrives the cycle after the strobe, i.e. during RCAP.
            if (r_state == S_RCAP) begin
                oResult[r_idx*DATA_WIDTH +: DATA_WIDTH] <= iReadData;
            end
            oBusy         <= (w_next_state != S_IDLE);
            oDone         <= (w_next_state == S_DONE);
            oChipSelect_n <= w_cs_n;
            oWrite_n      <= w_wr_n;
            oRead_n       <= w_rd_n;
            oAddress      <= w_addr;
            oWriteData    <= w_wdata;
        end
    end

endmodule
